rr_grant_arbiter: RTL

- Round-robin arbiter sharing one resource among N = 1<<LEN requesters.
- Accepts a request vector and issues a registered one-hot grant plus its binary index.
- A grant is held until the owner drops its request or a hold-time limit expires.
- Sits in front of any shared resource that is selected by a decoded one-hot enable.

---
 rtl/rr_grant_arbiter_pkg.sv | 24 ++
 rtl/rr_grant_arbiter_rr_pick.sv | 45 ++++
 rtl/rr_grant_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter.
// Holds the FSM state encoding, the hold counter width and the helper that
// derives the requester count N from the index width LEN.
package rr_grant_arbiter_pkg;

    // Two-state ownership FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Width of the per-ownership hold counter (saturating)
    localparam int unsigned HOLD_W = 8;

    // Default index width and the matching requester count
    localparam int unsigned LEN_DEF = 2;
    localparam int unsigned N_DEF   = 32'd1 << LEN_DEF;

    // Requester count for a given index width: N = 1 << LEN
    function automatic int unsigned n_of(input int unsigned len);
        return 32'd1 << len;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_rr_pick.sv
// Combinational round-robin winner selection.
// Ports:
//   req       [N]   request vector, bit i is requester i
//   ptr       [LEN] requester scanned first
//   win_id    [LEN] first set request at or after ptr (wrapping), 0 if none
//   win_valid [1]   any request set
// The request vector is rotated so ptr lands on bit 0, a lowest-bit-first
// fixed-priority scan finds the winner, and adding ptr back un-rotates it.
module rr_pick
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned LEN = 2
) (
    input  logic [n_of(LEN)-1:0] req,
    input  logic [LEN-1:0]       ptr,
    output logic [LEN-1:0]       win_id,
    output logic                 win_valid
);
    localparam int unsigned N = n_of(LEN);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [LEN-1:0] idx_s;

    // Rotate right by ptr using a doubled copy so bits wrap around
    assign dbl_s = {req, req} >> ptr;
    assign rot_s = dbl_s[N-1:0];

    // Fixed-priority scan: walk downward so the lowest set bit wins last
    always_comb begin
        idx_s = {LEN{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                idx_s = LEN'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Un-rotate: the index arithmetic wraps modulo N by width
    assign win_id    = idx_s + ptr;
    assign win_valid = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one resource among N = 1<<LEN requesters.
// Ports:
//   clk         [1]   rising-edge system clock
//   rst_n       [1]   asynchronous active-low reset
//   en          [1]   arbitration enable; low blocks new grants only
//   req         [N]   per-requester request level
//   grant       [N]   registered one-hot grant, zero when idle
//   grant_id    [LEN] index of current owner, valid with grant_valid
//   grant_valid [1]   high while a grant is held
//   timeout     [1]   one-cycle pulse when MAX_HOLD revokes a grant
// Every release or timeout passes through IDLE for one cycle, so two owners
// never hold adjacent grants. MAX_HOLD = 0 disables the timeout.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned LEN      = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [n_of(LEN)-1:0] req,
    output logic [n_of(LEN)-1:0] grant,
    output logic [LEN-1:0]       grant_id,
    output logic                 grant_valid,
    output logic                 timeout
);
    localparam int unsigned      N          = n_of(LEN);
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [N-1:0]     ONE_N      = {{(N-1){1'b0}}, 1'b1};

    state_e              state_q,       state_d;
    logic [LEN-1:0]      ptr_q,         ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q,    hold_cnt_d;
    logic [N-1:0]        grant_q,       grant_d;
    logic [LEN-1:0]      grant_id_q,    grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic                timeout_q,     timeout_d;

    logic [LEN-1:0]      win_id_s;
    logic                win_valid_s;

    rr_pick #(
        .LEN (LEN)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .win_id    (win_id_s),
        .win_valid (win_valid_s)
    );

    // Next-state logic: issue, hold, release or time out the grant
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && win_valid_s) begin
                    grant_id_d    = win_id_s;
                    grant_d       = ONE_N << win_id_s;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 8'd1;
                    state_d       = ST_BUSY;
                end else begin
                    grant_d       = {N{1'b0}};
                    grant_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (!req[grant_id_q]) begin
                    grant_d       = {N{1'b0}};
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = 8'd0;
                    ptr_d         = grant_id_q + LEN'(1);
                    state_d       = ST_IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C)) begin
                    grant_d       = {N{1'b0}};
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = 8'd0;
                    ptr_d         = grant_id_q + LEN'(1);
                    timeout_d     = 1'b1;
                    state_d       = ST_IDLE;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d    = hold_cnt_q + 8'd1;
                end else begin
                    // Saturate instead of wrapping on very long ownerships
                    hold_cnt_d    = hold_cnt_q;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = {N{1'b0}};
                grant_valid_d = 1'b0;
                hold_cnt_d    = 8'd0;
            end
        endcase
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= {LEN{1'b0}};
            hold_cnt_q    <= 8'd0;
            grant_q       <= {N{1'b0}};
            grant_id_q    <= {LEN{1'b0}};
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
